encoder_4to2: RTL and testbench

//  Registered 4-to-2 binary encoder. Four request lines y3..y0 are encoded to a 2-bit index a1:a0.

---
 rtl/encoder_4to2.sv | 64 ++++++
 tb/tb_encoder_4to2.sv | 132 +++++++++++++
 2 files changed

// File: rtl/encoder_4to2.sv
// Registered 4-to-2 encoder with validity and multi-hot flags.
// Encoding style is selectable: highest-index priority or plain OR encoding.
module encoder_4to2 #(
    parameter int PRIORITY = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic y3,
    input  logic y2,
    input  logic y1,
    input  logic y0,
    output logic a1,
    output logic a0,
    output logic valid,
    output logic multi
);

    logic [3:0] w_y;
    logic [1:0] w_idx;
    logic       w_any;
    logic       w_multi;

    logic [1:0] r_idx;
    logic       r_valid;
    logic       r_multi;

    assign w_y = {y3, y2, y1, y0};

    generate
        if (PRIORITY != 0) begin : g_priority
            always_comb begin
                w_idx = 2'b00;
                if (w_y[3])      w_idx = 2'b11;
                else if (w_y[2]) w_idx = 2'b10;
                else if (w_y[1]) w_idx = 2'b01;
            end
        end else begin : g_or
            // Multi-hot inputs alias onto the OR of their indices.
            assign w_idx = {w_y[3] | w_y[2], w_y[3] | w_y[1]};
        end
    endgenerate

    assign w_any   = |w_y;
    assign w_multi = (w_y[3] & w_y[2]) | (w_y[3] & w_y[1]) | (w_y[3] & w_y[0])
                   | (w_y[2] & w_y[1]) | (w_y[2] & w_y[0]) | (w_y[1] & w_y[0]);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx   <= 2'b00;
            r_valid <= 1'b0;
            r_multi <= 1'b0;
        end else begin
            r_idx   <= w_idx;
            r_valid <= w_any;
            r_multi <= w_multi;
        end
    end

    assign a1    = r_idx[1];
    assign a0    = r_idx[0];
    assign valid = r_valid;
    assign multi = r_multi;

endmodule

// File: tb/tb_encoder_4to2.sv
// Directed bench for encoder_4to2: priority and OR-encoding instances driven
// from one stimulus stream and compared against hand-computed tables.
module tb_encoder_4to2;

    logic clk = 1'b0;
    logic rst;
    logic y3, y2, y1, y0;
    logic p_a1, p_a0, p_valid, p_multi;
    logic o_a1, o_a0, o_valid, o_multi;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    encoder_4to2 #(.PRIORITY(1)) u_pri (
        .clk(clk), .rst(rst), .y3(y3), .y2(y2), .y1(y1), .y0(y0),
        .a1(p_a1), .a0(p_a0), .valid(p_valid), .multi(p_multi)
    );

    encoder_4to2 #(.PRIORITY(0)) u_or (
        .clk(clk), .rst(rst), .y3(y3), .y2(y2), .y1(y1), .y0(y0),
        .a1(o_a1), .a0(o_a0), .valid(o_valid), .multi(o_multi)
    );

    typedef struct {
        logic [3:0] y;
        logic [1:0] a_pri;
        logic [1:0] a_or;
        logic       v;
        logic       m;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [1:0] ep, input logic [1:0] eo,
                         input logic ev, input logic em);
        n_cmp++;
        if ({p_a1, p_a0, p_valid, p_multi} !== {ep, ev, em}) begin
            n_err++;
            $display("FAIL %s (PRIORITY=1): got a=%b%b valid=%b multi=%b, want a=%b valid=%b multi=%b",
                     name, p_a1, p_a0, p_valid, p_multi, ep, ev, em);
        end
        n_cmp++;
        if ({o_a1, o_a0, o_valid, o_multi} !== {eo, ev, em}) begin
            n_err++;
            $display("FAIL %s (PRIORITY=0): got a=%b%b valid=%b multi=%b, want a=%b valid=%b multi=%b",
                     name, o_a1, o_a0, o_valid, o_multi, eo, ev, em);
        end
    endtask

    task automatic drive(input logic r, input logic [3:0] y);
        @(negedge clk);
        rst = r;
        {y3, y2, y1, y0} = y;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0]  = '{4'b0001, 2'b00, 2'b00, 1'b1, 1'b0};
        vecs[1]  = '{4'b0010, 2'b01, 2'b01, 1'b1, 1'b0};
        vecs[2]  = '{4'b0100, 2'b10, 2'b10, 1'b1, 1'b0};
        vecs[3]  = '{4'b1000, 2'b11, 2'b11, 1'b1, 1'b0};
        vecs[4]  = '{4'b0000, 2'b00, 2'b00, 1'b0, 1'b0};
        vecs[5]  = '{4'b0110, 2'b10, 2'b11, 1'b1, 1'b1};
        vecs[6]  = '{4'b1111, 2'b11, 2'b11, 1'b1, 1'b1};
        vecs[7]  = '{4'b0011, 2'b01, 2'b01, 1'b1, 1'b1};
        vecs[8]  = '{4'b0101, 2'b10, 2'b10, 1'b1, 1'b1};
        vecs[9]  = '{4'b0111, 2'b10, 2'b11, 1'b1, 1'b1};
        vecs[10] = '{4'b1001, 2'b11, 2'b11, 1'b1, 1'b1};
        vecs[11] = '{4'b1010, 2'b11, 2'b11, 1'b1, 1'b1};
        vecs[12] = '{4'b1100, 2'b11, 2'b11, 1'b1, 1'b1};
        vecs[13] = '{4'b1011, 2'b11, 2'b11, 1'b1, 1'b1};
        vecs[14] = '{4'b1101, 2'b11, 2'b11, 1'b1, 1'b1};
        vecs[15] = '{4'b1110, 2'b11, 2'b11, 1'b1, 1'b1};

        rst = 1'b1;
        {y3, y2, y1, y0} = 4'b1111;

        // Reset held for two edges with all requests active.
        drive(1'b1, 4'b1111);
        check("reset_edge1", 2'b00, 2'b00, 1'b0, 1'b0);
        drive(1'b1, 4'b1111);
        check("reset_edge2", 2'b00, 2'b00, 1'b0, 1'b0);

        for (int i = 0; i < 16; i++) begin
            drive(1'b0, vecs[i].y);
            check($sformatf("vec_%b", vecs[i].y), vecs[i].a_pri, vecs[i].a_or, vecs[i].v, vecs[i].m);
        end

        // Reset pulse in the middle of a one-hot walk; no warm-up afterwards.
        drive(1'b0, 4'b0010);
        check("walk_pre_rst", 2'b01, 2'b01, 1'b1, 1'b0);
        drive(1'b1, 4'b0100);
        check("walk_in_rst", 2'b00, 2'b00, 1'b0, 1'b0);
        drive(1'b0, 4'b0100);
        check("walk_post_rst", 2'b10, 2'b10, 1'b1, 1'b0);

        // Input glitches between edges must not reach the registered outputs.
        drive(1'b0, 4'b1000);
        check("hold_base", 2'b11, 2'b11, 1'b1, 1'b0);
        {y3, y2, y1, y0} = 4'b0011;
        #1;
        check("hold_glitch_a", 2'b11, 2'b11, 1'b1, 1'b0);
        {y3, y2, y1, y0} = 4'b0000;
        #1;
        check("hold_glitch_b", 2'b11, 2'b11, 1'b1, 1'b0);
        {y3, y2, y1, y0} = 4'b0110;
        #1;
        {y3, y2, y1, y0} = 4'b1000;
        @(negedge clk);
        {y3, y2, y1, y0} = 4'b0001;
        #4;
        check("before_edge", 2'b11, 2'b11, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        check("after_edge", 2'b00, 2'b00, 1'b1, 1'b0);

        // Back-to-back transitions, each visible exactly one edge later.
        drive(1'b0, 4'b0110);
        check("b2b_0110", 2'b10, 2'b11, 1'b1, 1'b1);
        drive(1'b0, 4'b0000);
        check("b2b_0000", 2'b00, 2'b00, 1'b0, 1'b0);
        drive(1'b0, 4'b1111);
        check("b2b_1111", 2'b11, 2'b11, 1'b1, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
